// File: rtl/bullet_pkg.sv
// Shared constants, slot record and helpers for the bullet pool.
package bullet_pkg;

  localparam logic [1:0] DIR_STILL = 2'b00;
  localparam logic [1:0] DIR_POS   = 2'b01;
  localparam logic [1:0] DIR_NEG   = 2'b10;

  localparam int unsigned REC_X_W = 8;
  localparam int unsigned REC_Y_W = 7;
  localparam int unsigned AGE_W   = 8;

  typedef struct packed {
    logic [REC_X_W-1:0] x;
    logic [REC_Y_W-1:0] y;
    logic [1:0]         dx;
    logic [1:0]         dy;
    logic [AGE_W-1:0]   age;
    logic               active;
  } slot_t;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_SCAN,
    SCAN_PRESENT
  } scan_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet record: spawn load, per-tick motion with retire, and kill.
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int unsigned X_W      = REC_X_W,
  parameter int unsigned Y_W      = REC_Y_W,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned SPEED    = 2,
  parameter int unsigned LIFETIME = 60
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic [X_W-1:0] ld_x_i,
  input  logic [Y_W-1:0] ld_y_i,
  input  logic [1:0]     ld_dx_i,
  input  logic [1:0]     ld_dy_i,
  input  logic           move_i,
  input  logic           kill_i,
  output logic           active_o,
  output logic           active_nxt_c,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o
);

  localparam int unsigned XW1 = X_W + 1;
  localparam int unsigned YW1 = Y_W + 1;
  localparam int unsigned AW1 = AGE_W + 1;

  slot_t          rec_q, rec_d;
  logic [XW1-1:0] nx_c;
  logic [YW1-1:0] ny_c;
  logic           out_c;
  logic           expire_c;

  // Load only targets a free slot; kill beats motion on a live slot.
  always_comb begin
    rec_d = rec_q;
    nx_c  = {1'b0, X_W'(rec_q.x)};
    ny_c  = {1'b0, Y_W'(rec_q.y)};
    if (rec_q.dx == DIR_POS)      nx_c = nx_c + XW1'(SPEED);
    else if (rec_q.dx == DIR_NEG) nx_c = nx_c - XW1'(SPEED);
    if (rec_q.dy == DIR_POS)      ny_c = ny_c + YW1'(SPEED);
    else if (rec_q.dy == DIR_NEG) ny_c = ny_c - YW1'(SPEED);
    out_c    = (nx_c >= XW1'(SCREEN_W)) || (ny_c >= YW1'(SCREEN_H));
    expire_c = (LIFETIME != 0) &&
               (({1'b0, rec_q.age} + AW1'(1)) == AW1'(LIFETIME));

    if (load_i) begin
      rec_d.x      = REC_X_W'(ld_x_i);
      rec_d.y      = REC_Y_W'(ld_y_i);
      rec_d.dx     = ld_dx_i;
      rec_d.dy     = ld_dy_i;
      rec_d.age    = '0;
      rec_d.active = 1'b1;
    end else if (rec_q.active) begin
      if (kill_i) begin
        rec_d.active = 1'b0;
      end else if (move_i) begin
        if (out_c || expire_c) begin
          rec_d.active = 1'b0;
        end else begin
          rec_d.x   = REC_X_W'(nx_c[X_W-1:0]);
          rec_d.y   = REC_Y_W'(ny_c[Y_W-1:0]);
          rec_d.age = rec_q.age + AGE_W'(1);
        end
      end
    end
    active_nxt_c = rec_d.active;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rec_q <= '0;
    else        rec_q <= rec_d;
  end

  assign active_o = rec_q.active;
  assign x_o      = X_W'(rec_q.x);
  assign y_o      = Y_W'(rec_q.y);

endmodule

// File: rtl/bullet_pool.sv
// Bullet pool: fire edge detect, priority allocator, cooldown, plot scanner, live counter.
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int unsigned NUM_BULLETS = 16,
  parameter int unsigned X_W         = REC_X_W,
  parameter int unsigned Y_W         = REC_Y_W,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned LIFETIME    = 60,
  parameter int unsigned COOLDOWN    = 8,
  localparam int unsigned IDX_W      = clog2(NUM_BULLETS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fire,
  input  logic [1:0]             direct_x,
  input  logic [1:0]             direct_y,
  input  logic [X_W-1:0]         ship_x,
  input  logic [Y_W-1:0]         ship_y,
  input  logic                   tick,
  input  logic                   kill_valid,
  input  logic [IDX_W-1:0]       kill_idx,
  output logic                   plot_valid,
  input  logic                   plot_ready,
  output logic [X_W-1:0]         plot_x,
  output logic [Y_W-1:0]         plot_y,
  output logic [IDX_W-1:0]       plot_idx,
  output logic [NUM_BULLETS-1:0] active_mask,
  output logic [IDX_W:0]         live_count,
  output logic                   fire_accepted,
  output logic                   pool_full,
  output logic                   tick_overrun
);

  localparam int unsigned CD_W  = clog2(COOLDOWN + 2);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic                   fire_q1, fire_q2;
  logic [CD_W-1:0]        cd_q, cd_d;
  logic                   fa_q;
  logic                   rise_c, moving_c, accept_c, any_free_c;
  logic [IDX_W-1:0]       free_idx_c;
  logic [NUM_BULLETS-1:0] load_c, kill_c, act_nxt_c;
  logic [CNT_W-1:0]       cnt_q, cnt_c;
  logic                   full_q;
  logic [X_W-1:0]         slot_x [NUM_BULLETS];
  logic [Y_W-1:0]         slot_y [NUM_BULLETS];

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d, overrun_q, overrun_d, move_c, last_c;
  logic             pv_q, pv_d;
  logic [X_W-1:0]   px_q, px_d;
  logic [Y_W-1:0]   py_q, py_d;
  logic [IDX_W-1:0] pidx_q, pidx_d;

  // Lowest-index free slot, taken from the mask before any same-cycle kill.
  always_comb begin
    any_free_c = 1'b0;
    free_idx_c = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!active_mask[i]) begin
        any_free_c = 1'b1;
        free_idx_c = IDX_W'(i);
      end
    end
  end

  always_comb begin
    rise_c   = fire_q1 & ~fire_q2;
    moving_c = (direct_x == DIR_POS) || (direct_x == DIR_NEG) ||
               (direct_y == DIR_POS) || (direct_y == DIR_NEG);
    accept_c = rise_c && (cd_q == '0) && any_free_c && moving_c;
    cd_d     = cd_q;
    if (accept_c)          cd_d = CD_W'(COOLDOWN);
    else if (cd_q != '0)   cd_d = cd_q - CD_W'(1);
    load_c = '0;
    if (accept_c) load_c[free_idx_c] = 1'b1;
    kill_c = '0;
    if (kill_valid) kill_c[kill_idx] = 1'b1;
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_slot #(
      .X_W(X_W), .Y_W(Y_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
      .SPEED(SPEED), .LIFETIME(LIFETIME)
    ) u_slot (
      .clk          (clk),
      .rst_n        (reset),
      .load_i       (load_c[g]),
      .ld_x_i       (ship_x),
      .ld_y_i       (ship_y),
      .ld_dx_i      (direct_x),
      .ld_dy_i      (direct_y),
      .move_i       (move_c),
      .kill_i       (kill_c[g]),
      .active_o     (active_mask[g]),
      .active_nxt_c (act_nxt_c[g]),
      .x_o          (slot_x[g]),
      .y_o          (slot_y[g])
    );
  end

  // Count the next mask so the registered count lines up with active_mask.
  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < NUM_BULLETS; i++) cnt_c = cnt_c + CNT_W'(act_nxt_c[i]);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    move_c    = 1'b0;
    pv_d      = pv_q;
    px_d      = px_q;
    py_d      = py_q;
    pidx_d    = pidx_q;
    last_c    = (idx_q == IDX_W'(NUM_BULLETS - 1));

    if (tick && (state_q != SCAN_IDLE)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      SCAN_IDLE: begin
        if (tick || pending_q) begin
          move_c    = 1'b1;
          idx_d     = '0;
          pending_d = pending_q && tick;
          state_d   = SCAN_SCAN;
        end
      end
      SCAN_SCAN: begin
        if (active_mask[idx_q]) begin
          pv_d    = 1'b1;
          px_d    = slot_x[idx_q];
          py_d    = slot_y[idx_q];
          pidx_d  = idx_q;
          state_d = SCAN_PRESENT;
        end else if (last_c) begin
          state_d = SCAN_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SCAN_PRESENT: begin
        if (plot_ready) begin
          pv_d = 1'b0;
          if (last_c) begin
            state_d = SCAN_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SCAN_SCAN;
          end
        end
      end
      default: state_d = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fire_q1   <= 1'b0;
      fire_q2   <= 1'b0;
      cd_q      <= '0;
      fa_q      <= 1'b0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      state_q   <= SCAN_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      pv_q      <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      pidx_q    <= '0;
    end else begin
      fire_q1   <= fire;
      fire_q2   <= fire_q1;
      cd_q      <= cd_d;
      fa_q      <= accept_c;
      cnt_q     <= cnt_c;
      full_q    <= &act_nxt_c;
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      pv_q      <= pv_d;
      px_q      <= px_d;
      py_q      <= py_d;
      pidx_q    <= pidx_d;
    end
  end

  assign plot_valid    = pv_q;
  assign plot_x        = px_q;
  assign plot_y        = py_q;
  assign plot_idx      = pidx_q;
  assign live_count    = cnt_q;
  assign fire_accepted = fa_q;
  assign pool_full     = full_q;
  assign tick_overrun  = overrun_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: 4 slots, lifetime 3, other parameters default.
module tb_bullet_pool;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned RW = XW + YW + IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fire = 1'b0, tick = 1'b0, kill_valid = 1'b0, plot_ready = 1'b1;
  logic [1:0]    direct_x = 2'b00, direct_y = 2'b00;
  logic [IW-1:0] kill_idx = '0;
  logic [XW-1:0] ship_x = '0;
  logic [YW-1:0] ship_y = '0;

  logic          plot_valid, fire_accepted, pool_full, tick_overrun;
  logic [XW-1:0] plot_x;
  logic [YW-1:0] plot_y;
  logic [IW-1:0] plot_idx;
  logic [N-1:0]  active_mask;
  logic [IW:0]   live_count;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
  logic          hold = 1'b0;
  logic [RW-1:0] held = '0;

  bullet_pool #(.NUM_BULLETS(N), .LIFETIME(3)) dut (
    .clk(clk), .reset(rst_n), .fire(fire), .direct_x(direct_x), .direct_y(direct_y),
    .ship_x(ship_x), .ship_y(ship_y), .tick(tick), .kill_valid(kill_valid),
    .kill_idx(kill_idx), .plot_valid(plot_valid), .plot_ready(plot_ready),
    .plot_x(plot_x), .plot_y(plot_y), .plot_idx(plot_idx), .active_mask(active_mask),
    .live_count(live_count), .fire_accepted(fire_accepted), .pool_full(pool_full),
    .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] mk(input int x, input int y, input int idx);
    return {XW'(x), YW'(y), IW'(idx)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fire = 1'b0; tick = 1'b0; kill_valid = 1'b0; plot_ready = 1'b1;
    exp_q.delete();
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic press(input int x, input int y, input logic [1:0] dx, input logic [1:0] dy);
    ship_x = XW'(x); ship_y = YW'(y); direct_x = dx; direct_y = dy;
    fire = 1'b1;
    step();
    fire = 1'b0;
    step();
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: pops on every handshake and checks records hold under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        checks++;
        if (!plot_valid || {plot_x, plot_y, plot_idx} != held) begin
          errors++;
          $display("FAIL stable: got v=%0b rec=%0h expected v=1 rec=%0h",
                   plot_valid, {plot_x, plot_y, plot_idx}, held);
        end
      end
      if (plot_valid && plot_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL record: got unexpected %0h expected none", {plot_x, plot_y, plot_idx});
        end else begin
          logic [RW-1:0] e;
          e = exp_q.pop_front();
          if ({plot_x, plot_y, plot_idx} != e) begin
            errors++;
            $display("FAIL record: got %0h expected %0h", {plot_x, plot_y, plot_idx}, e);
          end
        end
      end
      hold = plot_valid && !plot_ready;
      held = {plot_x, plot_y, plot_idx};
    end
  end

  initial begin
    step(2);
    chk("reset_outs", {plot_valid, active_mask, live_count, fire_accepted, pool_full, tick_overrun}, 0);
    chk("reset_plot", {plot_x, plot_y, plot_idx}, 0);
    rst_n = 1'b1;
    step();

    // Still direction (00 and 11) is rejected.
    press(80, 60, 2'b00, 2'b00);
    chk("still00_fa", fire_accepted, 0);
    chk("still00_mask", active_mask, 0);
    step(3);
    press(80, 60, 2'b11, 2'b11);
    chk("still11_mask", active_mask, 0);

    // Fire once, then one tick.
    do_reset();
    ship_x = 8'd80; ship_y = 7'd60; direct_x = 2'b01; direct_y = 2'b00;
    fire = 1'b1;
    step();
    chk("fire_n1", fire_accepted, 0);
    fire = 1'b0;
    step();
    chk("fire_n2", fire_accepted, 1);
    chk("fire_mask", active_mask, 4'b0001);
    chk("fire_cnt", live_count, 1);
    step();
    chk("fire_pulse", fire_accepted, 0);
    exp_q.push_back(mk(82, 60, 0));
    pulse_tick();
    chk("plot_t1", plot_valid, 0);
    step();
    chk("plot_t2", plot_valid, 1);
    drain("fire_drain");
    step(4);

    // Pool full: 5 presses spaced COOLDOWN+2.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      press(10, 10 + k * 10, 2'b01, 2'b00);
      chk("pf_acc", fire_accepted, (k < 4) ? 1 : 0);
      chk("pf_cnt", live_count, (k < 4) ? k + 1 : 4);
      step(8);
    end
    chk("pf_mask", active_mask, 4'hF);
    chk("pf_full", pool_full, 1);

    // Edge exit on overflow and underflow.
    do_reset();
    press(158, 10, 2'b01, 2'b00);
    chk("edge_hi_live", active_mask, 4'b0001);
    pulse_tick();
    step(3);
    chk("edge_hi_gone", active_mask, 0);
    chk("edge_hi_cnt", live_count, 0);
    step(6);
    press(1, 10, 2'b10, 2'b00);
    chk("edge_lo_live", active_mask, 4'b0001);
    pulse_tick();
    step(3);
    chk("edge_lo_gone", active_mask, 0);

    // Lifetime 3.
    do_reset();
    press(10, 10, 2'b01, 2'b00);
    exp_q.push_back(mk(12, 10, 0));
    pulse_tick();
    drain("life_d1");
    chk("life_t1", active_mask, 4'b0001);
    exp_q.push_back(mk(14, 10, 0));
    pulse_tick();
    drain("life_d2");
    chk("life_t2", active_mask, 4'b0001);
    pulse_tick();
    step(5);
    chk("life_t3", active_mask, 0);

    // Kill in the allocation cycle.
    do_reset();
    press(20, 20, 2'b01, 2'b00);
    step(8);
    press(20, 30, 2'b01, 2'b00);
    chk("kr_two", active_mask, 4'b0011);
    step(8);
    ship_y = 7'd40;
    fire = 1'b1;
    step();
    fire = 1'b0; kill_valid = 1'b1; kill_idx = 2'd0;
    step();
    kill_valid = 1'b0;
    chk("kr_fa", fire_accepted, 1);
    chk("kr_mask", active_mask, 4'b0110);
    step(8);
    press(20, 50, 2'b01, 2'b00);
    chk("kr_reuse", active_mask, 4'b0111);
    chk("kr_cnt", live_count, 3);

    // Backpressure with pending tick and overrun.
    do_reset();
    press(30, 30, 2'b01, 2'b01);
    step(8);
    press(40, 40, 2'b01, 2'b01);
    step(8);
    press(50, 50, 2'b01, 2'b01);
    chk("bp_mask", active_mask, 4'b0111);
    exp_q.push_back(mk(32, 32, 0));
    exp_q.push_back(mk(42, 42, 1));
    exp_q.push_back(mk(52, 52, 2));
    exp_q.push_back(mk(34, 34, 0));
    exp_q.push_back(mk(44, 44, 1));
    exp_q.push_back(mk(54, 54, 2));
    plot_ready = 1'b0;
    pulse_tick();
    for (int i = 0; i < 10 && !plot_valid; i++) step();
    chk("bp_valid", plot_valid, 1);
    tick = 1'b1;
    step(2);
    tick = 1'b0;
    chk("bp_overrun", tick_overrun, 1);
    step(8);
    chk("bp_held", {plot_valid, plot_x, plot_idx}, {1'b1, 8'd32, 2'd0});
    plot_ready = 1'b1;
    drain("bp_drain");
    chk("bp_sticky", tick_overrun, 1);
    step(3);
    chk("bp_idle", plot_valid, 0);

    do_reset();
    chk("rst_overrun", tick_overrun, 0);
    chk("rst_mask", {active_mask, live_count}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
